// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
//
// Purpose:
//   Downstream stage of a weight-stationary PE column. It sums the K signed
//   products of one dot product into a wide accumulator. When the last term
//   arrives, it offers the result on a valid/ready port in two forms:
//     - out_acc : full-precision signed sum
//     - out_q   : int8 requantised copy (round half up, arithmetic shift,
//                 saturate) for the next layer's activations
//
// Parameters:
//   IN_W   width of the signed product input
//   ACC_W  accumulator width; keep ACC_W >= IN_W + LEN_W so that a
//          maximum-length dot product cannot overflow
//   LEN_W  width of cfg_len (terms per dot product)
//   Q_W    width of the requantised output
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   begin a dot product; only honoured in IDLE
//   cfg_len    in   number of terms K, latched when start is accepted
//   cfg_shift  in   requantisation right shift, latched when start is accepted
//   in_valid   in   in_data carries a term
//   in_ready   out  accumulator takes a term this cycle (registered)
//   in_data    in   signed product from the PE
//   out_valid  out  result is being offered (registered)
//   out_ready  in   consumer takes the result
//   out_acc    out  signed full-precision sum
//   out_q      out  signed requantised sum
//   busy       out  high whenever the FSM is not in IDLE
//   dbg_state  out  raw FSM state: 0 = IDLE, 1 = ACCUM, 2 = OUT
//
// Handshake rule (both ports):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The side that asserts valid holds its data stable until that transfer
//   happens. in_ready and out_valid come straight from flops, so they never
//   depend combinationally on the other side's signals.
// ---------------------------------------------------------------------------
module psum_accumulator #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 32,
    parameter int LEN_W = 16,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [4:0]       cfg_shift,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [Q_W-1:0]   out_q,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    // Saturation bounds, held in the same ACC_W+1 bit signed domain as the
    // shifted value so that the comparisons below are plain signed compares.
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(2**(Q_W-1) - 1);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-(2**(Q_W-1)));

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [4:0]         shift_q;
    logic [ACC_W-1:0]   acc_q;
    logic [LEN_W-1:0]   count_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_acc_q;
    logic [Q_W-1:0]     out_q_q;

    // ------------------------------------------------------------------
    // Next-value datapath
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   acc_d;
    logic [LEN_W-1:0]   count_d;
    logic               beat;
    logic               last_beat;
    logic [Q_W-1:0]     q_d;

    // Requantisation intermediates (one extra bit of headroom so that the
    // rounding add cannot wrap for any accumulator value).
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    assign in_ext    = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign acc_d     = acc_q + in_ext;
    assign count_d   = count_q + LEN_W'(1);
    assign beat      = in_valid && in_ready_q;
    // The beat that brings the count up to len is the final term.
    assign last_beat = (count_d == len_q);

    // The requantised value is formed from acc_d, so on the final beat it is
    // captured together with the full sum in the same edge. This gives the
    // one-cycle result latency.
    always_comb begin
        wide    = {acc_d[ACC_W-1], acc_d};
        rnd     = '0;
        if (shift_q != 5'd0) begin
            rnd = (ACC_W+1)'(1) << (shift_q - 5'd1);
        end
        rounded = wide + rnd;
        shifted = rounded >>> shift_q;

        if (shifted > Q_MAX) begin
            q_d = Q_MAX[Q_W-1:0];
        end else if (shifted < Q_MIN) begin
            q_d = Q_MIN[Q_W-1:0];
        end else begin
            q_d = shifted[Q_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            shift_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_q_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    if (start) begin
                        len_q   <= cfg_len;
                        shift_q <= cfg_shift;
                        acc_q   <= '0;
                        count_q <= '0;
                        if (cfg_len == '0) begin
                            // Empty dot product: the result is zero and is
                            // offered on the very next cycle.
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                            out_acc_q   <= '0;
                            out_q_q     <= '0;
                        end else begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                ST_ACCUM: begin
                    // start is ignored here. There is no timeout: acc and
                    // count simply hold while no term arrives.
                    if (beat) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (last_beat) begin
                            state_q     <= ST_OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_acc_q   <= acc_d;
                            out_q_q     <= q_d;
                        end
                    end
                end

                ST_OUT: begin
                    // Results stay frozen until they are taken. A start that
                    // arrives in the same cycle as the handshake is ignored,
                    // because the FSM is still in OUT during that cycle.
                    in_ready_q <= 1'b0;
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_q     = out_q_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc;
  logic [7:0]  out_q;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // terms of the job currently being driven
  logic signed [15:0] terms[$];

  psum_accumulator #(.IN_W(16), .ACC_W(32), .LEN_W(16), .Q_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_q(out_q), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint model_sum(input int len);
    longint s = 0;
    for (int i = 0; i < len; i++) s += longint'(terms[i]);
    return s;
  endfunction

  // round half up, then floor-divide by 2^sh, then saturate to int8
  function automatic logic [7:0] model_q(input longint s, input int sh);
    longint num, d, r;
    if (sh == 0) begin
      r = s;
    end else begin
      d = longint'(1) << sh;
      num = s + (d / 2);
      r = num / d;
      if ((num % d) != 0 && num < 0) r = r - 1;
    end
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // ---------------- driver ----------------
  // Drives one complete job and reports what it observed. All sampling
  // happens 1 time unit after a rising edge.
  task automatic run_job(input int len, input int sh, input int gap_mode,
                         input int hold, input bit poke, input bit start_at_hs,
                         output logic [31:0] g_acc, output logic [7:0] g_q,
                         output bit lat_ok, output bit stable_ok,
                         output bit ird_ok, output bit idle_ok);
    int idx;
    int cyc;
    bit v;
    bit taken;
    g_acc = 'x; g_q = 'x;
    lat_ok = 1; stable_ok = 1; ird_ok = 1; idle_ok = 1;
    if (in_ready !== 1'b0) ird_ok = 0;
    start = 1'b1; cfg_len = len[15:0]; cfg_shift = sh[4:0];
    @(posedge clk); #1;
    start = 1'b0; cfg_len = 16'($urandom); cfg_shift = 5'($urandom);
    idx = 0; cyc = 0;
    while (idx < len && cyc < 400) begin
      case (gap_mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data = terms[idx];
      if (poke) begin start = 1'($urandom_range(0, 1)); cfg_len = 16'd1; end
      taken = v && (in_ready === 1'b1);
      if (out_valid !== 1'b0) lat_ok = 0;
      @(posedge clk); #1;
      if (taken) idx++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (idx < len) begin
      lat_ok = 0;
      return;
    end
    if (out_valid !== 1'b1) begin
      lat_ok = 0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (out_valid !== 1'b1) return;
    end
    if (in_ready !== 1'b0) ird_ok = 0;
    g_acc = out_acc; g_q = out_q;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin start = 1'b1; cfg_len = 16'd3; end
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_acc !== g_acc || out_q !== g_q) stable_ok = 0;
      if (in_ready !== 1'b0) ird_ok = 0;
    end
    out_ready = 1'b1;
    start = start_at_hs; cfg_len = 16'd1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) idle_ok = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (out_acc !== 32'd0) begin n_fail++; $display("FAIL reset_out_acc got=%h exp=0", out_acc); end
    n_tests++; if (out_q !== 8'd0) begin n_fail++; $display("FAIL reset_out_q got=%h exp=0", out_q); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_basic;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    terms = {16'sd10, -16'sd3, 16'sd7, 16'sd2};
    run_job(4, 0, 0, 0, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'd16) begin n_fail++; $display("FAIL basic_acc got=%0d exp=16", $signed(a)); end
    n_tests++; if (q !== 8'd16) begin n_fail++; $display("FAIL basic_q got=%0d exp=16", $signed(q)); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL basic_latency got=%b exp=1", l); end
    n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL basic_idle_after got=%b exp=1", d); end
  endtask

  task automatic test_round;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    terms = {16'sd5, 16'sd6, -16'sd5};
    run_job(3, 2, 0, 0, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'd6) begin n_fail++; $display("FAIL round_acc got=%0d exp=6", $signed(a)); end
    n_tests++; if (q !== 8'd2) begin n_fail++; $display("FAIL round_q_pos got=%0d exp=2", $signed(q)); end
    terms = {-16'sd7};
    run_job(1, 1, 0, 0, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL round_acc_neg got=%0d exp=-7", $signed(a)); end
    n_tests++; if (q !== 8'hFD) begin n_fail++; $display("FAIL round_q_neg got=%0d exp=-3", $signed(q)); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL round_latency_len1 got=%b exp=1", l); end
  endtask

  task automatic test_saturate;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    terms = {16'sd16384, 16'sd16384};
    run_job(2, 0, 0, 0, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'd32768) begin n_fail++; $display("FAIL sat_acc_pos got=%0d exp=32768", $signed(a)); end
    n_tests++; if (q !== 8'd127) begin n_fail++; $display("FAIL sat_q_pos got=%0d exp=127", $signed(q)); end
    terms = {-16'sd16256, -16'sd16256};
    run_job(2, 0, 0, 0, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'hFFFF_8100) begin n_fail++; $display("FAIL sat_acc_neg got=%0d exp=-32512", $signed(a)); end
    n_tests++; if (q !== 8'h80) begin n_fail++; $display("FAIL sat_q_neg got=%0d exp=-128", $signed(q)); end
  endtask

  task automatic test_len_zero;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    terms = {};
    run_job(0, 3, 0, 2, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'd0) begin n_fail++; $display("FAIL len0_acc got=%h exp=0", a); end
    n_tests++; if (q !== 8'd0) begin n_fail++; $display("FAIL len0_q got=%h exp=0", q); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL len0_latency got=%b exp=1", l); end
    n_tests++; if (s !== 1'b1) begin n_fail++; $display("FAIL len0_stable got=%b exp=1", s); end
  endtask

  task automatic test_handshake;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    longint es;
    terms = {};
    for (int k = 0; k < 6; k++) terms.push_back(16'($urandom));
    es = model_sum(6);
    run_job(6, 4, 1, 5, 1, 0, a, q, l, s, i, d);
    n_tests++; if (a !== es[31:0]) begin n_fail++; $display("FAIL hs_acc got=%0d exp=%0d", $signed(a), es); end
    n_tests++; if (q !== model_q(es, 4)) begin n_fail++; $display("FAIL hs_q got=%0d exp=%0d", $signed(q), $signed(model_q(es, 4))); end
    n_tests++; if (s !== 1'b1) begin n_fail++; $display("FAIL hs_stable got=%b exp=1", s); end
    n_tests++; if (i !== 1'b1) begin n_fail++; $display("FAIL hs_in_ready_low got=%b exp=1", i); end
    n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL hs_idle_after got=%b exp=1", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    terms = {16'sd100};
    run_job(1, 0, 0, 0, 0, 0, a, q, l, s, i, d);
    start = 1'b1; cfg_len = 16'd5; cfg_shift = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 16'd1000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if (out_acc !== 32'd0) begin n_fail++; $display("FAIL rstmid_out_acc got=%h exp=0", out_acc); end
    n_tests++; if (out_q !== 8'd0) begin n_fail++; $display("FAIL rstmid_out_q got=%h exp=0", out_q); end
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl got busy=%b in_ready=%b out_valid=%b exp=0,0,0", busy, in_ready, out_valid);
    end
    terms = {16'sd21, -16'sd4};
    run_job(2, 0, 0, 0, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'd17) begin n_fail++; $display("FAIL rstmid_fresh_acc got=%0d exp=17", $signed(a)); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    terms = {16'sd3, 16'sd4};
    run_job(2, 0, 0, 1, 0, 1, a, q, l, s, i, d);
    n_tests++; if (a !== 32'd7) begin n_fail++; $display("FAIL b2b_first_acc got=%0d exp=7", $signed(a)); end
    n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL b2b_start_at_hs_ignored got=%b exp=1", d); end
    terms = {-16'sd1, -16'sd2, -16'sd3};
    run_job(3, 0, 0, 0, 0, 0, a, q, l, s, i, d);
    n_tests++; if (a !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL b2b_second_acc got=%0d exp=-6", $signed(a)); end
    n_tests++; if (q !== 8'hFA) begin n_fail++; $display("FAIL b2b_second_q got=%0d exp=-6", $signed(q)); end
    n_tests++; if (i !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_low got=%b exp=1", i); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL b2b_latency got=%b exp=1", l); end
  endtask

  task automatic test_random;
    logic [31:0] a; logic [7:0] q; bit l, s, i, d;
    longint es;
    int len, sh;
    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(1, 20);
      sh = $urandom_range(0, 12);
      terms = {};
      for (int k = 0; k < len; k++) terms.push_back(16'($urandom));
      es = model_sum(len);
      run_job(len, sh, 2, $urandom_range(0, 3), 1, 0, a, q, l, s, i, d);
      n_tests++; if (a !== es[31:0]) begin n_fail++; $display("FAIL rand%0d_acc got=%0d exp=%0d", it, $signed(a), es); end
      n_tests++; if (q !== model_q(es, sh)) begin n_fail++; $display("FAIL rand%0d_q got=%0d exp=%0d sh=%0d", it, $signed(q), $signed(model_q(es, sh)), sh); end
      n_tests++; if ((l & s & i & d) !== 1'b1) begin n_fail++; $display("FAIL rand%0d_proto got lat=%b stable=%b inrdy=%b idle=%b exp=1111", it, l, s, i, d); end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_shift = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_len_zero();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
